// File: rtl/am_insert_tx.sv
// 40GBASE-R TX alignment marker insertion with per-lane BIP.
// Define AM_INSERT_BIP_EN to build the BIP accumulators (else BIP3=00, BIP7=FF).
module am_insert_tx #(
  parameter int LANE_N      = 4,
  parameter int HEAD_W      = 2,
  parameter int DATA_W      = 64,
  parameter int BLOCK_W     = HEAD_W + DATA_W,
  parameter int AM_INTERVAL = 16384
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [LANE_N*BLOCK_W-1:0] block_i,
  input  logic                      ready_i,
  output logic                      valid_o,
  output logic                      am_v_o,
  output logic [LANE_N*BLOCK_W-1:0] block_o
);

  localparam int CW = (AM_INTERVAL > 1) ? $clog2(AM_INTERVAL) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(AM_INTERVAL - 1);

  // {M2,M1,M0} so that M0 lands in data[7:0]
  function automatic logic [23:0] am_m(input int l);
    logic [23:0] m;
    case (l)
      0:       m = 24'h477690;
      1:       m = 24'hE6C4F0;
      2:       m = 24'h9B65C5;
      default: m = 24'h3D79A2;
    endcase
    return m;
  endfunction

  function automatic logic [BLOCK_W-1:0] am_blk(
    input int         l,
    input logic [7:0] bip
  );
    logic [23:0] m;
    m = am_m(l);
    return {~bip, ~m, bip, m, 2'b01};
  endfunction

  function automatic logic [7:0] fold(input logic [BLOCK_W-1:0] b);
    logic [7:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) begin
        f[i] = f[i] ^ b[2+i+8*k];
      end
    end
    f[3] = f[3] ^ b[0];
    f[4] = f[4] ^ b[1];
    return f;
  endfunction

  logic                      valid_q, valid_d;
  logic                      am_q, am_d;
  logic [LANE_N*BLOCK_W-1:0] block_q, block_d;
  logic [CW-1:0]             cnt_q, cnt_d;
`ifdef AM_INSERT_BIP_EN
  logic [LANE_N-1:0][7:0]    acc_q, acc_d;
`endif

  logic                      adv;
  logic                      am_slot;
  logic [CW-1:0]             cnt_inc;
  logic [BLOCK_W-1:0]        am_l;

  always_comb begin
    adv     = ready_i | ~valid_q;
    am_slot = (cnt_q == '0);
    cnt_inc = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    ready_o = ~reset & adv & ~am_slot;
    valid_d = valid_q;
    am_d    = am_q;
    block_d = block_q;
    cnt_d   = cnt_q;
    am_l    = '0;
`ifdef AM_INSERT_BIP_EN
    acc_d   = acc_q;
`endif
    if (adv) begin
      if (am_slot) begin
        valid_d = 1'b1;
        am_d    = 1'b1;
        cnt_d   = cnt_inc;
        for (int l = 0; l < LANE_N; l++) begin
`ifdef AM_INSERT_BIP_EN
          am_l     = am_blk(l, acc_q[l]);
          // the AM itself opens the next interval
          acc_d[l] = fold(am_l);
`else
          am_l     = am_blk(l, 8'h00);
`endif
          block_d[l*BLOCK_W +: BLOCK_W] = am_l;
        end
      end else if (valid_i) begin
        valid_d = 1'b1;
        am_d    = 1'b0;
        block_d = block_i;
        cnt_d   = cnt_inc;
`ifdef AM_INSERT_BIP_EN
        for (int l = 0; l < LANE_N; l++) begin
          acc_d[l] = acc_q[l] ^ fold(block_i[l*BLOCK_W +: BLOCK_W]);
        end
`endif
      end else begin
        valid_d = 1'b0;
        am_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      am_q    <= 1'b0;
      block_q <= '0;
      cnt_q   <= '0;
`ifdef AM_INSERT_BIP_EN
      acc_q   <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      am_q    <= am_d;
      block_q <= block_d;
      cnt_q   <= cnt_d;
`ifdef AM_INSERT_BIP_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign am_v_o  = am_q;
  assign block_o = block_q;

endmodule

// File: tb/tb_am_insert_tx.sv
// Directed table-driven bench for am_insert_tx with AM_INTERVAL=8.
module tb_am_insert_tx;

  localparam int LN = 4;
  localparam int BW = 66;
  localparam int TW = LN * BW;

`ifdef AM_INSERT_BIP_EN
  localparam logic [7:0] B08 = 8'h08;
  localparam logic [7:0] B09 = 8'h09;
`else
  localparam logic [7:0] B08 = 8'h00;
  localparam logic [7:0] B09 = 8'h00;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_i;
  logic          ready_o;
  logic [TW-1:0] block_i;
  logic          ready_i;
  logic          valid_o;
  logic          am_v_o;
  logic [TW-1:0] block_o;

  am_insert_tx #(.AM_INTERVAL(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .block_i (block_i),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .am_v_o  (am_v_o),
    .block_o (block_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, vi, ri, fl;
    logic       er, ev, ea;
    int         seq;
    logic [7:0] b, b2;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   up_seq = 0;

  function automatic vec_t V(logic rst, logic vi, logic ri, logic fl,
                             logic er, logic ev, logic ea, int seq,
                             logic [7:0] b, logic [7:0] b2);
    vec_t v;
    v.rst = rst; v.vi = vi; v.ri = ri; v.fl = fl;
    v.er = er; v.ev = ev; v.ea = ea; v.seq = seq;
    v.b = b; v.b2 = b2;
    return v;
  endfunction

  function automatic vec_t D(int s, logic fl);
    return V(0, 1, 1, fl, 1, 1, 0, s, 8'h00, 8'h00);
  endfunction

  function automatic vec_t A(logic [7:0] b, logic [7:0] b2);
    return V(0, 1, 1, 0, 0, 1, 1, 0, b, b2);
  endfunction

  // data payload whose bytes cancel pairwise, so its fold is zero
  function automatic logic [TW-1:0] mk_all(int seq, logic fl);
    logic [TW-1:0] r;
    logic [15:0]   s;
    logic [7:0]    ln;
    logic [BW-1:0] blk;
    s = 16'(seq);
    r = '0;
    for (int l = 0; l < LN; l++) begin
      ln  = 8'(l + 1);
      blk = {s, s, ln, ln, 16'h0000, 2'b00};
      if (fl && l == 2) blk[2] = ~blk[2];
      r[l*BW +: BW] = blk;
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] am_ref(int l, logic [7:0] b);
    logic [7:0] m0, m1, m2;
    case (l)
      0: begin m0 = 8'h90; m1 = 8'h76; m2 = 8'h47; end
      1: begin m0 = 8'hF0; m1 = 8'hC4; m2 = 8'hE6; end
      2: begin m0 = 8'hC5; m1 = 8'h65; m2 = 8'h9B; end
      default: begin m0 = 8'hA2; m1 = 8'h79; m2 = 8'h3D; end
    endcase
    return {~b, ~m2, ~m1, ~m0, b, m2, m1, m0, 2'b01};
  endfunction

  function automatic logic [TW-1:0] am_all(logic [7:0] b, logic [7:0] b2);
    logic [TW-1:0] r;
    for (int l = 0; l < LN; l++) begin
      r[l*BW +: BW] = am_ref(l, (l == 2) ? b2 : b);
    end
    return r;
  endfunction

  task automatic chk(string nm, int row, logic [TW-1:0] act,
                     logic [TW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h required %h", nm, row, act, exp);
    end
  endtask

  initial begin
    vq.push_back(V(1, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    vq.push_back(A(8'h00, 8'h00));
    for (int s = 0; s <= 6; s++) vq.push_back(D(s, 0));
    vq.push_back(A(B08, B08));
    for (int s = 7; s <= 13; s++) vq.push_back(D(s, s == 9));
    vq.push_back(A(B08, B09));
    vq.push_back(D(14, 0));
    vq.push_back(D(15, 0));
    for (int i = 0; i < 3; i++)
      vq.push_back(V(0, 1, 0, 0, 0, 1, 0, 15, 8'h00, 8'h00));
    for (int s = 16; s <= 20; s++) vq.push_back(D(s, 0));
    vq.push_back(A(B08, B08));
    vq.push_back(V(0, 0, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00));
    vq.push_back(D(21, 0));
    vq.push_back(V(0, 0, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00));
    vq.push_back(D(22, 0));
    vq.push_back(D(23, 0));
    vq.push_back(V(0, 0, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00));
    for (int s = 24; s <= 27; s++) vq.push_back(D(s, 0));
    vq.push_back(V(0, 0, 1, 0, 0, 1, 1, 0, B08, B08));
    vq.push_back(V(0, 1, 0, 0, 0, 1, 1, 0, B08, B08));
    for (int s = 28; s <= 30; s++) vq.push_back(D(s, 0));
    vq.push_back(V(1, 1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    vq.push_back(A(8'h00, 8'h00));
    vq.push_back(D(31, 0));
    vq.push_back(D(32, 0));

    reset   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    block_i = '0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      vec_t    r;
      logic    acc;
      r = vq[i];
      @(negedge clk);
      reset   = r.rst;
      valid_i = r.vi;
      ready_i = r.ri;
      block_i = mk_all(up_seq, r.fl);
      #1;
      chk("ready_o", i, TW'(ready_o), TW'(r.er));
      if (r.rst) begin
        chk("rst_valid", i, TW'(valid_o), '0);
        chk("rst_block", i, block_o, '0);
      end
      acc = valid_i & ready_o;
      @(posedge clk);
      #1;
      if (acc) up_seq++;
      chk("valid_o", i, TW'(valid_o), TW'(r.ev));
      chk("am_v_o", i, TW'(am_v_o), TW'(r.ea));
      if (r.rst) begin
        chk("block_rst", i, block_o, '0);
      end else if (r.ev) begin
        if (r.ea) chk("am_block", i, block_o, am_all(r.b, r.b2));
        else chk("data_block", i, block_o, mk_all(r.seq, r.fl));
      end
      if (i == 1) begin
        chk("am_lane0", i, TW'(block_o[65:2]), TW'(64'hFFB8896F00477690));
        chk("am_head0", i, TW'(block_o[1:0]), TW'(2'b01));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
